// File: rtl/store_drain_buffer.sv
// rtl/store_drain_buffer.sv - committed-store drain buffer with in-order cache writes and load forwarding
module store_drain_buffer #(
    parameter int DEPTH        = 8,
    parameter int COMMIT_WIDTH = 4,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [COMMIT_WIDTH-1:0]                cs_valid,
    input  logic [COMMIT_WIDTH*ADDR_WIDTH-1:0]     cs_addr,
    input  logic [COMMIT_WIDTH*DATA_WIDTH-1:0]     cs_data,
    input  logic [COMMIT_WIDTH*(DATA_WIDTH/8)-1:0] cs_be,
    output logic [$clog2(DEPTH):0]                 free_slots,
    output logic                                   empty,
    output logic                                   overflow,
    output logic                                   mem_req_valid,
    output logic [ADDR_WIDTH-1:0]                  mem_req_addr,
    output logic [DATA_WIDTH-1:0]                  mem_req_data,
    output logic [DATA_WIDTH/8-1:0]                mem_req_be,
    input  logic                                   mem_req_ready,
    input  logic                                   mem_ack,
    input  logic [ADDR_WIDTH-1:0]                  fwd_addr,
    output logic                                   fwd_hit,
    output logic [DATA_WIDTH-1:0]                  fwd_data,
    output logic [DATA_WIDTH/8-1:0]                fwd_be
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int BW = DATA_WIDTH / 8;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [BW-1:0]         be_q   [DEPTH];

    state_t          state;
    logic [PW-1:0]   head, tail, occ;
    logic [AW-1:0]   head_idx, next_idx;

    logic [COMMIT_WIDTH-1:0] wr_en;
    logic [AW-1:0]           wr_idx [COMMIT_WIDTH];
    logic [PW-1:0]           n_enq;
    logic                    ovf_now;
    logic [ADDR_WIDTH-1:0]   first_addr;
    logic [DATA_WIDTH-1:0]   first_data;
    logic [BW-1:0]           first_be;

    assign occ        = tail - head;
    assign free_slots = PW'(DEPTH) - occ;
    assign empty      = (occ == '0);
    assign head_idx   = head[AW-1:0];
    assign next_idx   = head_idx + AW'(1);

    // Compact valid slots into consecutive entries, dropping any beyond the free space.
    always_comb begin
        n_enq      = '0;
        ovf_now    = 1'b0;
        wr_en      = '0;
        first_addr = '0;
        first_data = '0;
        first_be   = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            wr_idx[i] = tail[AW-1:0] + n_enq[AW-1:0];
            if (cs_valid[i]) begin
                if (n_enq < free_slots) begin
                    wr_en[i] = 1'b1;
                    if (n_enq == '0) begin
                        first_addr = cs_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                        first_data = cs_data[i*DATA_WIDTH +: DATA_WIDTH];
                        first_be   = cs_be[i*BW +: BW];
                    end
                    n_enq = n_enq + PW'(1);
                end else begin
                    ovf_now = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (wr_en[i]) begin
                addr_q[wr_idx[i]] <= cs_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                data_q[wr_idx[i]] <= cs_data[i*DATA_WIDTH +: DATA_WIDTH];
                be_q[wr_idx[i]]   <= cs_be[i*BW +: BW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head          <= '0;
            tail          <= '0;
            overflow      <= 1'b0;
            state         <= S_IDLE;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_data  <= '0;
            mem_req_be    <= '0;
        end else begin
            tail <= tail + n_enq;
            if (ovf_now) overflow <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (occ != '0) begin
                        mem_req_valid <= 1'b1;
                        mem_req_addr  <= addr_q[head_idx];
                        mem_req_data  <= data_q[head_idx];
                        mem_req_be    <= be_q[head_idx];
                        state         <= S_REQ;
                    end else if (n_enq != '0) begin
                        // Empty buffer: the first incoming store lands at head, so bypass it.
                        mem_req_valid <= 1'b1;
                        mem_req_addr  <= first_addr;
                        mem_req_data  <= first_data;
                        mem_req_be    <= first_be;
                        state         <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        head <= head + PW'(1);
                        if (occ > PW'(1)) begin
                            mem_req_valid <= 1'b1;
                            mem_req_addr  <= addr_q[next_idx];
                            mem_req_data  <= data_q[next_idx];
                            mem_req_be    <= be_q[next_idx];
                            state         <= S_REQ;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Walk oldest to youngest so younger matching bytes overwrite older ones.
    logic [AW-1:0] fwd_idx;
    always_comb begin
        fwd_data = '0;
        fwd_be   = '0;
        fwd_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head_idx + AW'(k);
            if (PW'(k) < occ && addr_q[fwd_idx][ADDR_WIDTH-1:2] == fwd_addr[ADDR_WIDTH-1:2]) begin
                for (int b = 0; b < BW; b++) begin
                    if (be_q[fwd_idx][b]) fwd_data[b*8 +: 8] = data_q[fwd_idx][b*8 +: 8];
                end
                fwd_be = fwd_be | be_q[fwd_idx];
            end
        end
    end

    assign fwd_hit = |fwd_be;

    logic unused_fwd_lsb;
    assign unused_fwd_lsb = ^fwd_addr[1:0];
endmodule

// File: tb/tb_store_drain_buffer.sv
// tb/tb_store_drain_buffer.sv - directed self-checking bench for store_drain_buffer
module tb_store_drain_buffer;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   cs_valid = '0;
    logic [127:0] cs_addr = '0;
    logic [127:0] cs_data = '0;
    logic [15:0]  cs_be = '0;
    logic [3:0]   free_slots;
    logic         empty, overflow;
    logic         mem_req_valid;
    logic [31:0]  mem_req_addr, mem_req_data;
    logic [3:0]   mem_req_be;
    logic         mem_req_ready = 1'b0;
    logic         mem_ack = 1'b0;
    logic [31:0]  fwd_addr = '0;
    logic         fwd_hit;
    logic [31:0]  fwd_data;
    logic [3:0]   fwd_be;

    int checks = 0;
    int errors = 0;

    store_drain_buffer #(.DEPTH(8), .COMMIT_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .cs_valid(cs_valid), .cs_addr(cs_addr), .cs_data(cs_data), .cs_be(cs_be),
        .free_slots(free_slots), .empty(empty), .overflow(overflow),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_req_data(mem_req_data), .mem_req_be(mem_req_be),
        .mem_req_ready(mem_req_ready), .mem_ack(mem_ack),
        .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_be(fwd_be)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_slot(input int i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        cs_addr[i*32 +: 32] = a;
        cs_data[i*32 +: 32] = d;
        cs_be[i*4 +: 4]     = be;
    endtask

    task automatic drain_one(output logic [31:0] a, output logic [31:0] d);
        int n;
        n = 0;
        while (mem_req_valid !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk("drain_req_seen", {63'd0, mem_req_valid}, 64'd1);
        a = mem_req_addr;
        d = mem_req_data;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
    endtask

    initial begin
        logic [31:0] a, d;
        int sent, got, pending, cyc;

        // Reset state
        #1;
        chk("rst_free", free_slots, 8);
        chk("rst_empty", empty, 1);
        chk("rst_ovf", overflow, 0);
        chk("rst_valid", mem_req_valid, 0);
        chk("rst_addr", mem_req_addr, 0);
        chk("rst_fwd", {fwd_hit, fwd_be, fwd_data}, 0);
        step();
        rst_n = 1'b1;
        step();

        // Sparse commit, first request, back-to-back drain
        set_slot(0, 32'h100, 32'hAA, 4'hF);
        set_slot(2, 32'h200, 32'hBB, 4'hF);
        cs_valid = 4'b0101;
        step();
        cs_valid = '0;
        chk("t1_free", free_slots, 6);
        chk("t1_valid", mem_req_valid, 1);
        chk("t1_addr", mem_req_addr, 32'h100);
        chk("t1_data", mem_req_data, 32'hAA);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        chk("t1_valid_drop", mem_req_valid, 0);
        step();
        step();
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("t1_next_valid", mem_req_valid, 1);
        chk("t1_next_addr", mem_req_addr, 32'h200);
        chk("t1_next_data", mem_req_data, 32'hBB);
        chk("t1_free_after", free_slots, 7);

        // Stall: request must stay stable while ready is low
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_stable", {mem_req_valid, mem_req_be, mem_req_addr, mem_req_data[26:0]},
                {1'b1, 4'hF, 32'h200, 27'hBB});
        end
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("t2_empty", empty, 1);
        chk("t2_valid", mem_req_valid, 0);
        chk("t2_free", free_slots, 8);

        // Byte-merged forwarding
        set_slot(0, 32'h40, 32'h1111_2222, 4'b0011);
        set_slot(1, 32'h40, 32'h3333_4444, 4'b0110);
        cs_valid = 4'b0011;
        step();
        cs_valid = '0;
        fwd_addr = 32'h42;
        #1;
        chk("t3_hit", fwd_hit, 1);
        chk("t3_be", fwd_be, 4'b0111);
        chk("t3_data", fwd_data, 32'h0033_4422);
        fwd_addr = 32'h44;
        #1;
        chk("t3_miss", {fwd_hit, fwd_be, fwd_data}, 0);
        drain_one(a, d);
        chk("t3_d0", a, 32'h40);
        drain_one(a, d);
        chk("t3_d1", d, 32'h3333_4444);
        chk("t3_empty", empty, 1);

        // Fill to capacity, then overflow
        for (int i = 0; i < 4; i++) set_slot(i, 32'h1000 + i*4, 32'hD0 + i, 4'hF);
        cs_valid = 4'b1111;
        step();
        for (int i = 0; i < 4; i++) set_slot(i, 32'h1010 + i*4, 32'hD4 + i, 4'hF);
        step();
        cs_valid = '0;
        chk("t4_full", free_slots, 0);
        chk("t4_no_ovf", overflow, 0);
        for (int i = 0; i < 2; i++) set_slot(i, 32'h2000 + i*4, 32'hEE, 4'hF);
        cs_valid = 4'b0011;
        step();
        cs_valid = '0;
        chk("t4_ovf", overflow, 1);
        chk("t4_still_full", free_slots, 0);
        fwd_addr = 32'h2000;
        #1;
        chk("t4_dropped", fwd_hit, 0);
        fwd_addr = 32'h1014;
        #1;
        chk("t4_fwd_old", {fwd_hit, fwd_be, fwd_data}, {1'b1, 4'hF, 32'hD5});
        for (int i = 0; i < 8; i++) begin
            drain_one(a, d);
            chk("t4_order_addr", a, 32'h1000 + i*4);
            chk("t4_order_data", d, 32'hD0 + i);
        end
        chk("t4_empty", empty, 1);
        chk("t4_ovf_sticky", overflow, 1);

        // Streaming with concurrent enqueue and pop across pointer wraps
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t5_ovf_clear", overflow, 0);
        mem_req_ready = 1'b1;
        sent = 0;
        got = 0;
        pending = 0;
        cyc = 0;
        while (got < 20 && cyc < 400) begin
            mem_ack = (pending != 0);
            pending = mem_req_valid ? 1 : 0;
            if (mem_req_valid) begin
                chk("t5_addr", mem_req_addr, 32'h3000 + got*4);
                chk("t5_data", mem_req_data, got);
                got++;
            end
            if (sent < 20 && free_slots != 0) begin
                set_slot(0, 32'h3000 + sent*4, sent, 4'hF);
                cs_valid = 4'b0001;
                sent++;
            end else begin
                cs_valid = '0;
            end
            step();
            cyc++;
        end
        cs_valid = '0;
        mem_req_ready = 1'b0;
        mem_ack = (pending != 0);
        step();
        mem_ack = 1'b0;
        step();
        chk("t5_count", got, 20);
        chk("t5_no_ovf", overflow, 0);
        chk("t5_empty", empty, 1);

        // Reset while waiting for an ack
        for (int i = 0; i < 3; i++) set_slot(i, 32'h500 + i*4, 32'h77, 4'hF);
        cs_valid = 4'b0111;
        step();
        cs_valid = '0;
        chk("t6_valid", mem_req_valid, 1);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        chk("t6_free", free_slots, 5);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", mem_req_valid, 0);
        chk("t6_rst_empty", empty, 1);
        chk("t6_rst_free", free_slots, 8);
        step();
        rst_n = 1'b1;
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        step();
        chk("t6_late_ack", {mem_req_valid, empty, free_slots}, {1'b0, 1'b1, 4'd8});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
